// File: rtl/seq_chunk_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a registered
// carry chain, finishing a WIDTH-bit add or subtract in WIDTH/CHUNK RUN cycles.
module seq_chunk_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NCYC = WIDTH / CHUNK;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK:0]   csum;
    logic             msb_cin;
    logic [WIDTH-1:0] part_shift;

    // One chunk of the ripple; the carry into its top bit is recovered from the sum bit.
    always_comb begin
        csum       = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        msb_cin    = csum[CHUNK-1] ^ opa_q[CHUNK-1] ^ opb_q[CHUNK-1];
        part_shift = (part_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            carry_q  <= 1'b0;
            part_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            carry_q  <= carry_d;
            part_q   <= part_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        carry_d  = carry_q;
        part_d   = part_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                carry_d = csum[CHUNK];
                part_d  = part_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NCYC - 1)) begin
                    result_d = part_shift;
                    cout_d   = csum[CHUNK];
                    ovf_d    = msb_cin ^ csum[CHUNK];
                    zero_d   = (part_shift == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE);
        busy  = (state_q == S_RUN);
        done  = (state_q == S_DONE);
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Scoreboard bench for seq_chunk_addsub: a main 8/2 instance for directed tests plus
// a parameter sweep (8/1, 8/4, 8/8, 32/4) checked against a behavioural model.
module tb_seq_chunk_addsub;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
        int          done_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_m = 1'b0, start_s = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic sub = 1'b0, cin = 1'b0;
    int cyc = 0;
    int n_checks = 0, n_fail = 0;

    exp_t q_m[$], q_c1[$], q_c4[$], q_c8[$], q_w32[$];

    logic rdy_m, bsy_m, dn_m, co_m, ov_m, z_m;     logic [7:0]  res_m;
    logic rdy_c1, bsy_c1, dn_c1, co_c1, ov_c1, z_c1; logic [7:0]  res_c1;
    logic rdy_c4, bsy_c4, dn_c4, co_c4, ov_c4, z_c4; logic [7:0]  res_c4;
    logic rdy_c8, bsy_c8, dn_c8, co_c8, ov_c8, z_c8; logic [7:0]  res_c8;
    logic rdy_w, bsy_w, dn_w, co_w, ov_w, z_w;       logic [31:0] res_w;

    seq_chunk_addsub #(.WIDTH(8), .CHUNK(2)) dut_m (.clk(clk), .rst_n(rst_n), .start(start_m),
        .a(a8), .b(b8), .sub(sub), .cin(cin), .ready(rdy_m), .busy(bsy_m), .done(dn_m),
        .result(res_m), .cout(co_m), .overflow(ov_m), .zero(z_m));
    seq_chunk_addsub #(.WIDTH(8), .CHUNK(1)) dut_c1 (.clk(clk), .rst_n(rst_n), .start(start_s),
        .a(a8), .b(b8), .sub(sub), .cin(cin), .ready(rdy_c1), .busy(bsy_c1), .done(dn_c1),
        .result(res_c1), .cout(co_c1), .overflow(ov_c1), .zero(z_c1));
    seq_chunk_addsub #(.WIDTH(8), .CHUNK(4)) dut_c4 (.clk(clk), .rst_n(rst_n), .start(start_s),
        .a(a8), .b(b8), .sub(sub), .cin(cin), .ready(rdy_c4), .busy(bsy_c4), .done(dn_c4),
        .result(res_c4), .cout(co_c4), .overflow(ov_c4), .zero(z_c4));
    seq_chunk_addsub #(.WIDTH(8), .CHUNK(8)) dut_c8 (.clk(clk), .rst_n(rst_n), .start(start_s),
        .a(a8), .b(b8), .sub(sub), .cin(cin), .ready(rdy_c8), .busy(bsy_c8), .done(dn_c8),
        .result(res_c8), .cout(co_c8), .overflow(ov_c8), .zero(z_c8));
    seq_chunk_addsub #(.WIDTH(32), .CHUNK(4)) dut_w32 (.clk(clk), .rst_n(rst_n), .start(start_s),
        .a(a32), .b(b32), .sub(sub), .cin(cin), .ready(rdy_w), .busy(bsy_w), .done(dn_w),
        .result(res_w), .cout(co_w), .overflow(ov_w), .zero(z_w));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: two's-complement add of A and (B or ~B); overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   input logic c, input int w, input int ncyc);
        exp_t e;
        logic [32:0] mask, aa, bb, sum;
        mask = (33'd1 << w) - 33'd1;
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, (s ? ~b : b)} & mask;
        sum  = aa + bb + {32'd0, (s ? 1'b1 : c)};
        e.res = sum[31:0] & mask[31:0];
        e.co  = sum[w];
        e.ov  = (aa[w-1] == bb[w-1]) && (e.res[w-1] != aa[w-1]);
        e.z   = (e.res == 32'd0);
        e.done_at = cyc + ncyc + 1;
        return e;
    endfunction

    task automatic check_res(input string tag, input exp_t e, input logic [31:0] r,
                             input logic co, input logic ov, input logic z);
        chk({tag, "_result"}, r, e.res);
        chk({tag, "_cout"}, co, e.co);
        chk({tag, "_overflow"}, ov, e.ov);
        chk({tag, "_zero"}, z, e.z);
        chk({tag, "_done_cycle"}, cyc, e.done_at);
    endtask

    // Per-instance monitors: pop on done, flag spurious or missing done pulses.
    always @(negedge clk) if (rst_n) begin : mon_m
        exp_t e;
        if (dn_m) begin
            if (q_m.size() == 0) chk("m_spurious_done", 1, 0);
            else begin e = q_m.pop_front(); check_res("m", e, {24'd0, res_m}, co_m, ov_m, z_m); end
        end else if (q_m.size() > 0 && cyc > q_m[0].done_at) begin
            chk("m_done_missing", cyc, q_m[0].done_at); void'(q_m.pop_front());
        end
    end
    always @(negedge clk) if (rst_n) begin : mon_c1
        exp_t e;
        if (dn_c1) begin
            if (q_c1.size() == 0) chk("c1_spurious_done", 1, 0);
            else begin e = q_c1.pop_front(); check_res("c1", e, {24'd0, res_c1}, co_c1, ov_c1, z_c1); end
        end else if (q_c1.size() > 0 && cyc > q_c1[0].done_at) begin
            chk("c1_done_missing", cyc, q_c1[0].done_at); void'(q_c1.pop_front());
        end
    end
    always @(negedge clk) if (rst_n) begin : mon_c4
        exp_t e;
        if (dn_c4) begin
            if (q_c4.size() == 0) chk("c4_spurious_done", 1, 0);
            else begin e = q_c4.pop_front(); check_res("c4", e, {24'd0, res_c4}, co_c4, ov_c4, z_c4); end
        end else if (q_c4.size() > 0 && cyc > q_c4[0].done_at) begin
            chk("c4_done_missing", cyc, q_c4[0].done_at); void'(q_c4.pop_front());
        end
    end
    always @(negedge clk) if (rst_n) begin : mon_c8
        exp_t e;
        if (dn_c8) begin
            if (q_c8.size() == 0) chk("c8_spurious_done", 1, 0);
            else begin e = q_c8.pop_front(); check_res("c8", e, {24'd0, res_c8}, co_c8, ov_c8, z_c8); end
        end else if (q_c8.size() > 0 && cyc > q_c8[0].done_at) begin
            chk("c8_done_missing", cyc, q_c8[0].done_at); void'(q_c8.pop_front());
        end
    end
    always @(negedge clk) if (rst_n) begin : mon_w32
        exp_t e;
        if (dn_w) begin
            if (q_w32.size() == 0) chk("w32_spurious_done", 1, 0);
            else begin e = q_w32.pop_front(); check_res("w32", e, res_w, co_w, ov_w, z_w); end
        end else if (q_w32.size() > 0 && cyc > q_w32[0].done_at) begin
            chk("w32_done_missing", cyc, q_w32[0].done_at); void'(q_w32.pop_front());
        end
    end

    // Single op on the 8/2 instance; reports how many cycles busy was seen high.
    task automatic op_m(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                        output int busy_n);
        @(negedge clk);
        a8 = a; b8 = b; sub = s; cin = c; start_m = 1'b1;
        q_m.push_back(model({24'd0, a}, {24'd0, b}, s, c, 8, 4));
        busy_n = 0;
        @(negedge clk);
        start_m = 1'b0;
        a8 = ~a; b8 = a ^ b; sub = ~s; cin = ~c;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (bsy_m) busy_n++;
        end
    endtask

    initial begin
        int bn;
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy_m, 1'b1);
        chk("rst_busy", bsy_m, 1'b0);
        chk("rst_done", dn_m, 1'b0);
        chk("rst_flags", {res_m, co_m, ov_m, z_m}, 11'd0);
        rst_n = 1'b1;

        op_m(8'h3C, 8'h05, 1'b0, 1'b0, bn);
        chk("t1_busy_cycles", bn, 4);
        chk("t1_result_const", res_m, 8'h41);
        op_m(8'h7F, 8'h01, 1'b0, 1'b0, bn);
        op_m(8'hFF, 8'h00, 1'b0, 1'b1, bn);
        op_m(8'h10, 8'h20, 1'b1, 1'b1, bn);
        op_m(8'h80, 8'h01, 1'b1, 1'b0, bn);
        op_m(8'h55, 8'h55, 1'b1, 1'b0, bn);
        chk("t3_hold_result", res_m, 8'h00);

        // start held high: sampling only at IDLE edges, one op every 6 cycles
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("hs_ready", rdy_m, ((i - 1) % 6) == 5);
                chk("hs_busy", bsy_m, ((i - 1) % 6) < 4);
            end
            a8 = 8'($urandom); b8 = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            start_m = 1'b1;
            if (i % 6 == 0) q_m.push_back(model({24'd0, a8}, {24'd0, b8}, sub, cin, 8, 4));
        end
        @(negedge clk);
        start_m = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset in the second RUN cycle
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h05; sub = 1'b0; cin = 1'b0; start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", rdy_m, 1'b1);
        chk("arst_busy", bsy_m, 1'b0);
        chk("arst_done", dn_m, 1'b0);
        chk("arst_outputs", {res_m, co_m, ov_m, z_m}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        op_m(8'h01, 8'h01, 1'b0, 1'b0, bn);
        chk("t5_result_const", res_m, 8'h02);

        // random sweep across all instances
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
            sub = 1'($urandom); cin = 1'($urandom);
            if (n < 4) begin a8 = (n[0]) ? 8'hFF : 8'h00; b8 = (n[1]) ? 8'hFF : 8'h00; end
            start_m = 1'b1; start_s = 1'b1;
            q_m.push_back(model({24'd0, a8}, {24'd0, b8}, sub, cin, 8, 4));
            q_c1.push_back(model({24'd0, a8}, {24'd0, b8}, sub, cin, 8, 8));
            q_c4.push_back(model({24'd0, a8}, {24'd0, b8}, sub, cin, 8, 2));
            q_c8.push_back(model({24'd0, a8}, {24'd0, b8}, sub, cin, 8, 1));
            q_w32.push_back(model(a32, b32, sub, cin, 32, 8));
            @(negedge clk);
            start_m = 1'b0; start_s = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
            repeat (9) @(negedge clk);
        end

        repeat (12) @(negedge clk);
        chk("queues_drained", q_m.size() + q_c1.size() + q_c4.size() + q_c8.size() + q_w32.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_chunk_addsub.md
Name: seq_chunk_addsub

Overview:
- Multi-cycle, parametrised adder/subtractor for the ALU datapath.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock using a registered carry chain, in WIDTH/CHUNK cycles.
- Trades latency for a short critical path.
- Start/done handshake; reports sum, carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 4, bits processed per RUN cycle. Must satisfy 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0.
- NCYC (derived, not overridable), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored); sampled with start.
- cin  input  1  carry-in for add; sampled with start.
- ready  output  1  high only in IDLE.
- busy  output  1  high only in RUN.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  sum/difference.
- cout  output  1  carry out of the MSB. For sub, 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  high when result == 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, chunk counter=0, internal operand/carry regs=0. Outputs: ready=1, busy=0, done=0, result=0, cout=0, overflow=0, zero=0. Reset mid-RUN aborts the operation with no done pulse; output regs return to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at edge E, load opA=a, opB=(sub ? ~b : b), carry=(sub ? 1 : cin), counter=0; go to RUN.
  - RUN: each edge adds CHUNK LSBs of opA, opB plus carry. The CHUNK-bit sum fills the partial-result shift register from the MSB side, shifting right by CHUNK. opA/opB shift right by CHUNK, carry <= chunk carry-out, counter++.
  - On the edge where counter == NCYC-1: final chunk processed; result, cout, overflow, zero registered; go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally on the next edge.
- Latency: start sampled at edge E; RUN edges are E+1..E+NCYC. done is high in the cycle following edge E+NCYC, and outputs update at that edge. Throughput is one operation per NCYC+2 cycles.
- overflow: taken from the final chunk's MSB carry-in and carry-out. When CHUNK==1, the MSB carry-in is the registered carry.
- start while busy or in DONE is ignored; it is not queued. a/b/sub/cin may change freely after the start edge.
- result/cout/overflow/zero hold their values after done until the next operation completes; they do not change during RUN.
- CHUNK==WIDTH: a single RUN cycle, done at E+2 cycles.
- No X propagation: all regs are reset.

Test Plan (WIDTH=8, CHUNK=2, NCYC=4 unless stated):
1. a=0x3C, b=0x05, sub=0, cin=0, start pulse at edge E.
   - Required: busy high for 4 cycles; done high only in the cycle after edge E+4.
   - Required: result=0x41, cout=0, overflow=0, zero=0.
2. a=0x7F, b=0x01, add, cin=0 -> result=0x80, overflow=1, cout=0. Then a=0xFF, b=0x00, cin=1 -> result=0x00, cout=1, zero=1, overflow=0.
3. Subtraction cases:
   - sub=1, a=0x10, b=0x20, cin=1 (cin ignored) -> result=0xF0, cout=0, overflow=0.
   - sub=1, a=0x80, b=0x01 -> result=0x7F, cout=1, overflow=1.
   - sub=1, a=0x55, b=0x55 -> result=0x00, zero=1, cout=1.
4. Handshake:
   - Hold start=1 continuously with changing a/b. Required: each op uses operands sampled only at the IDLE edge; done pulses every 6 cycles; ready is low in RUN and DONE.
   - Change a/b mid-RUN. Required: the result is unaffected.
5. Reset cases:
   - Assert rst_n=0 asynchronously in RUN cycle 2. Required: outputs go to 0 immediately with no done pulse; ready=1.
   - Release reset and start a=0x01, b=0x01. Required: result=0x02.
6. Parameter sweep: CHUNK in {1, 2, 4, 8} with WIDTH=8, and WIDTH=32/CHUNK=4.
   - Required: CHUNK=8 gives done in the cycle after edge E+1.
   - Run 1000 random operands (add and sub, random cin) against a behavioural model. Required: result/cout/overflow/zero all match.
